// File: rtl/filter_output_pkg.sv
// filter_output_pkg: shared definitions for the filter output stage.
//   - default accumulator/output widths
//   - signed saturation limit helpers
//   - clog2 helper for FIFO pointer sizing
`ifndef FILTER_OUTPUT_PKG_SV
`define FILTER_OUTPUT_PKG_SV
package filter_output_pkg;

  localparam int unsigned ACC_WIDTH_DEF = 32;
  localparam int unsigned OUT_WIDTH_DEF = 16;

  // Largest value representable in a w-bit two's complement word
  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Ceiling log2, valid for v >= 1
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage
`endif

// File: rtl/filter_output_stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with registered head and valid.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_wr_val        write request (ignored when full unless a read happens)
//   i_wr_data       write data
//   o_rd_val        head valid
//   o_rd_data       head data (registered)
//   i_rd_rdy        sink accepts head
//   o_count         current occupancy
module stream_fifo
  import filter_output_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_val,
  input  logic [WIDTH-1:0]          i_wr_data,
  output logic                      o_rd_val,
  output logic [WIDTH-1:0]          o_rd_data,
  input  logic                      i_rd_rdy,
  output logic [clog2_f(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = clog2_f(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_val;

  logic             w_rd;
  logic             w_wr;
  logic             w_full;
  logic [CNT_W-1:0] w_count_nxt;

  // Handshake decode: a full FIFO still accepts a write when the head leaves
  always_comb begin
    w_rd        = r_val & i_rd_rdy;
    w_full      = (r_count == CNT_W'(DEPTH));
    w_wr        = i_wr_val & (~w_full | w_rd);
    w_count_nxt = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers, count and registered head
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_val    <= 1'b0;
      r_head   <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_val   <= (w_count_nxt != '0);
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Head follows the next stored word, or the incoming word when that is next
      if (w_rd) begin
        if (r_count > CNT_W'(1)) r_head <= r_mem[r_rd_ptr + PTR_W'(1)];
        else if (w_wr)           r_head <= i_wr_data;
      end else if (~r_val && w_wr) begin
        r_head <= i_wr_data;
      end
    end
  end

  assign o_rd_val  = r_val;
  assign o_rd_data = r_head;
  assign o_count   = r_count;

endmodule

// File: rtl/filter_output.sv
// filter_output: output conditioning at the tail of the MAC chain.
// S1 captures the accumulator, S2 shifts (optionally rounding), S3 saturates,
// then beats enter a FWFT FIFO toward the sink.
// Build option: define ROUND_EN for round-half-up; otherwise truncate (floor).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_shift/val   shift amount load; cfg_val also clears sticky flags
//   up_acc/up_val   accumulator beat from the last tap (no backpressure)
//   up_afull        registered throttle request to the stream source
//   dn_data/val/rdy conditioned sample handshake toward the sink
//   sat_err         sticky: a sample was clamped
//   ovf_err         sticky: a beat was dropped on a full FIFO
module filter_output
  import filter_output_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AFULL       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_val,
  input  logic [ACC_WIDTH-1:0]   up_acc,
  input  logic                   up_val,
  output logic                   up_afull,
  output logic [OUT_WIDTH-1:0]   dn_data,
  output logic                   dn_val,
  input  logic                   dn_rdy,
  output logic                   sat_err,
  output logic                   ovf_err
);

  localparam int unsigned EXT_W = ACC_WIDTH + 1;
  localparam int unsigned CNT_W = clog2_f(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 2;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(OUT_WIDTH));
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(OUT_WIDTH));

  logic [SHIFT_WIDTH-1:0]    r_shift;
  logic                      r_s1_val;
  logic [ACC_WIDTH-1:0]      r_s1_acc;
  logic [SHIFT_WIDTH-1:0]    r_s1_shift;
  logic                      r_s2_val;
  logic signed [EXT_W-1:0]   r_s2_data;
  logic                      r_s3_val;
  logic [OUT_WIDTH-1:0]      r_s3_data;
  logic                      r_s3_clamp;
  logic                      r_afull;
  logic                      r_sat_err;
  logic                      r_ovf_err;

  logic signed [EXT_W-1:0]   w_s2_ext;
  logic signed [EXT_W-1:0]   w_s2_nxt;
  logic [OUT_WIDTH-1:0]      w_s3_nxt;
  logic                      w_clamp;
  logic [CNT_W-1:0]          w_count;
  logic [OCC_W-1:0]          w_occ;
  logic                      w_drop;

  // S2: sign-extend one bit so the rounding add cannot wrap, then shift
  always_comb begin
    w_s2_ext = {r_s1_acc[ACC_WIDTH-1], r_s1_acc};
`ifdef ROUND_EN
    if (r_s1_shift != '0)
      w_s2_ext = w_s2_ext + (EXT_W'(1) << (r_s1_shift - SHIFT_WIDTH'(1)));
`endif
    w_s2_nxt = w_s2_ext >>> r_s1_shift;
  end

  // S3: clamp to the signed output range
  always_comb begin
    w_clamp  = 1'b0;
    w_s3_nxt = r_s2_data[OUT_WIDTH-1:0];
    if (r_s2_data > SAT_HI) begin
      w_clamp  = 1'b1;
      w_s3_nxt = SAT_HI[OUT_WIDTH-1:0];
    end else if (r_s2_data < SAT_LO) begin
      w_clamp  = 1'b1;
      w_s3_nxt = SAT_LO[OUT_WIDTH-1:0];
    end
  end

  // Occupancy including in-flight beats, and drop detection on a full FIFO
  always_comb begin
    w_occ  = OCC_W'(w_count) + OCC_W'(r_s1_val) + OCC_W'(r_s2_val) + OCC_W'(r_s3_val);
    w_drop = r_s3_val & (w_count == CNT_W'(DEPTH)) & ~dn_rdy;
  end

  // Pipeline stages, shift register and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_s1_val   <= 1'b0;
      r_s1_acc   <= '0;
      r_s1_shift <= '0;
      r_s2_val   <= 1'b0;
      r_s2_data  <= '0;
      r_s3_val   <= 1'b0;
      r_s3_data  <= '0;
      r_s3_clamp <= 1'b0;
      r_afull    <= 1'b0;
      r_sat_err  <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (cfg_val) r_shift <= cfg_shift;
      // Shift travels with the beat so a load never affects an already captured beat
      r_s1_val   <= up_val;
      r_s1_acc   <= up_acc;
      r_s1_shift <= r_shift;
      r_s2_val   <= r_s1_val;
      r_s2_data  <= w_s2_nxt;
      r_s3_val   <= r_s2_val;
      r_s3_data  <= w_s3_nxt;
      r_s3_clamp <= w_clamp;
      r_afull    <= (w_occ >= OCC_W'(AFULL));
      // Setting wins over a simultaneous clear
      if (r_s3_val && r_s3_clamp) r_sat_err <= 1'b1;
      else if (cfg_val)           r_sat_err <= 1'b0;
      if (w_drop)                 r_ovf_err <= 1'b1;
      else if (cfg_val)           r_ovf_err <= 1'b0;
    end
  end

  stream_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_val  (r_s3_val),
    .i_wr_data (r_s3_data),
    .o_rd_val  (dn_val),
    .o_rd_data (dn_data),
    .i_rd_rdy  (dn_rdy),
    .o_count   (w_count)
  );

  assign up_afull = r_afull;
  assign sat_err  = r_sat_err;
  assign ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_filter_output.sv
// Directed bench for filter_output: rounding/truncation, saturation,
// overflow with throttle, full-FIFO read/write, back-to-back and reset flush.
module tb_filter_output;

  logic        clk;
  logic        rst;
  logic [4:0]  cfg_shift;
  logic        cfg_val;
  logic [31:0] up_acc;
  logic        up_val;
  logic        up_afull;
  logic [15:0] dn_data;
  logic        dn_val;
  logic        dn_rdy;
  logic        sat_err;
  logic        ovf_err;

  int n_vec = 0;
  int n_bad = 0;

`ifdef ROUND_EN
  localparam logic [15:0] EXP_POS = 16'd19;
  localparam logic [15:0] EXP_NEG = 16'hFFEE;
`else
  localparam logic [15:0] EXP_POS = 16'd18;
  localparam logic [15:0] EXP_NEG = 16'hFFED;
`endif

  filter_output dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_shift (cfg_shift),
    .cfg_val   (cfg_val),
    .up_acc    (up_acc),
    .up_val    (up_val),
    .up_afull  (up_afull),
    .dn_data   (dn_data),
    .dn_val    (dn_val),
    .dn_rdy    (dn_rdy),
    .sat_err   (sat_err),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] s);
    cfg_shift = s;
    cfg_val   = 1'b1;
    tick();
    cfg_val   = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a);
    up_acc = a;
    up_val = 1'b1;
    tick();
    up_val = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_shift = '0; cfg_val = 1'b0; up_acc = '0; up_val = 1'b0; dn_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL rst_dn_val: got %b want 0", dn_val); end
    n_vec++; if (dn_data !== 16'h0000) begin n_bad++; $display("FAIL rst_dn_data: got %h want 0000", dn_data); end
    n_vec++; if (up_afull !== 1'b0) begin n_bad++; $display("FAIL rst_afull: got %b want 0", up_afull); end
    n_vec++; if ({sat_err, ovf_err} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {sat_err, ovf_err}); end
  endtask

  task automatic test_shift(input logic [31:0] a, input logic [15:0] exp, input string nm);
    cfg(5'd4);
    dn_rdy = 1'b1;
    send_beat(a);
    tick();
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL %s_early2: got %b want 0", nm, dn_val); end
    tick();
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL %s_early3: got %b want 0", nm, dn_val); end
    tick();
    n_vec++; if (dn_val !== 1'b1) begin n_bad++; $display("FAIL %s_val: got %b want 1", nm, dn_val); end
    n_vec++; if (dn_data !== exp) begin n_bad++; $display("FAIL %s_data: got %h want %h", nm, dn_data, exp); end
    tick();
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL %s_drained: got %b want 0", nm, dn_val); end
  endtask

  task automatic test_saturate;
    cfg(5'd0);
    dn_rdy = 1'b1;
    up_val = 1'b1; up_acc = 32'h7FFF_FFFF; tick();
    up_acc = 32'h8000_0000; tick();
    up_val = 1'b0;
    tick(); tick();
    n_vec++; if (dn_data !== 16'h7FFF || dn_val !== 1'b1) begin n_bad++; $display("FAIL sat_hi: got %h/%b want 7fff/1", dn_data, dn_val); end
    n_vec++; if (sat_err !== 1'b1) begin n_bad++; $display("FAIL sat_err_set: got %b want 1", sat_err); end
    tick();
    n_vec++; if (dn_data !== 16'h8000 || dn_val !== 1'b1) begin n_bad++; $display("FAIL sat_lo: got %h/%b want 8000/1", dn_data, dn_val); end
    tick();
    n_vec++; if (sat_err !== 1'b1) begin n_bad++; $display("FAIL sat_err_sticky: got %b want 1", sat_err); end
    cfg(5'd0);
    n_vec++; if (sat_err !== 1'b0) begin n_bad++; $display("FAIL sat_err_clear: got %b want 0", sat_err); end
  endtask

  task automatic test_overflow;
    cfg(5'd0);
    dn_rdy = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      up_val = 1'b1; up_acc = 32'(k);
      tick();
      if (k == 4) begin
        n_vec++; if (up_afull !== 1'b0) begin n_bad++; $display("FAIL afull_early: got %b want 0", up_afull); end
      end
      if (k == 5) begin
        n_vec++; if (up_afull !== 1'b1) begin n_bad++; $display("FAIL afull_rise: got %b want 1", up_afull); end
      end
    end
    up_val = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    n_vec++; if (sat_err !== 1'b0) begin n_bad++; $display("FAIL ovf_no_sat: got %b want 0", sat_err); end
    dn_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (dn_val !== 1'b1 || dn_data !== 16'(k)) begin
        n_bad++; $display("FAIL ovf_drain%0d: got %h/%b want %h/1", k, dn_data, dn_val, 16'(k));
      end
      tick();
    end
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", dn_val); end
    tick();
    n_vec++; if (up_afull !== 1'b0) begin n_bad++; $display("FAIL afull_fall: got %b want 0", up_afull); end
  endtask

  task automatic test_full_rw;
    cfg(5'd0);
    dn_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      up_val = 1'b1; up_acc = 32'(20 + k);
      tick();
    end
    up_val = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (dn_data !== 16'd21 || up_afull !== 1'b1) begin n_bad++; $display("FAIL frw_fill: got %h/%b want 0015/1", dn_data, up_afull); end
    send_beat(32'd29);
    tick(); tick();
    dn_rdy = 1'b1;
    tick();
    dn_rdy = 1'b0;
    n_vec++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL frw_no_ovf: got %b want 0", ovf_err); end
    n_vec++; if (dn_data !== 16'd22 || dn_val !== 1'b1) begin n_bad++; $display("FAIL frw_head: got %h/%b want 0016/1", dn_data, dn_val); end
    tick();
    dn_rdy = 1'b1;
    for (int k = 22; k <= 29; k++) begin
      n_vec++;
      if (dn_val !== 1'b1 || dn_data !== 16'(k)) begin
        n_bad++; $display("FAIL frw_drain%0d: got %h/%b want %h/1", k, dn_data, dn_val, 16'(k));
      end
      tick();
    end
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL frw_count: got %b want 0", dn_val); end
  endtask

  task automatic test_back_to_back;
    cfg(5'd1);
    dn_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      up_val = 1'b1; up_acc = 32'(2 * k);
      tick();
    end
    up_val = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if (dn_val !== 1'b1 || dn_data !== 16'(k)) begin
        n_bad++; $display("FAIL b2b_%0d: got %h/%b want %h/1", k, dn_data, dn_val, 16'(k));
      end
      tick();
    end
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", dn_val); end
  endtask

  task automatic test_mid_reset;
    cfg(5'd4);
    dn_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      up_val = 1'b1; up_acc = 32'(16 * k);
      tick();
    end
    up_val = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL mrst_val: got %b want 0", dn_val); end
    n_vec++; if (up_afull !== 1'b0) begin n_bad++; $display("FAIL mrst_afull: got %b want 0", up_afull); end
    tick(); tick(); tick();
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL mrst_flush: got %b want 0", dn_val); end
    dn_rdy = 1'b1;
    send_beat(32'd288);
    tick(); tick();
    n_vec++; if (dn_val !== 1'b0) begin n_bad++; $display("FAIL mrst_early: got %b want 0", dn_val); end
    tick();
    n_vec++; if (dn_val !== 1'b1 || dn_data !== 16'h0120) begin n_bad++; $display("FAIL mrst_beat: got %h/%b want 0120/1", dn_data, dn_val); end
  endtask

  initial begin
    test_reset();
    test_shift(32'd296, EXP_POS, "pos");
    test_shift(32'hFFFF_FED8, EXP_NEG, "neg");
    test_saturate();
    test_overflow();
    test_full_rw();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/filter_output.md
# filter_output

Output conditioning stage at the tail of the stream-filter MAC chain. Consumes the raw accumulator from the last multiply-add tap and applies a programmable arithmetic right shift, optional rounding and signed saturation to the output width. Results are buffered in a small first-word-fall-through FIFO with valid/ready handshake toward the downstream sink. The MAC chain cannot stall, so the block raises an almost-full flag to throttle the stream source and flags any lost beat.

## Interface

- ACC_WIDTH, 32, accumulator width (IMG_WIDTH+KER_WIDTH of the chain).
- OUT_WIDTH, 16, signed output sample width; must be ≤ ACC_WIDTH.
- SHIFT_WIDTH, 5, width of the shift amount; legal shift values 0..ACC_WIDTH-1.
- DEPTH, 8, FIFO depth; power of two, ≥ 4.
- AFULL, 4, occupancy threshold for up_afull; must be < DEPTH.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount.
- cfg_val  in  1  loads cfg_shift; clears sat_err and ovf_err.
- up_acc  in  ACC_WIDTH  signed accumulator from last tap.
- up_val  in  1  up_acc valid this cycle; there is no ready.
- up_afull  out  1  registered throttle request to stream source.
- dn_data  out  OUT_WIDTH  signed conditioned sample (FIFO head).
- dn_val  out  1  dn_data valid.
- dn_rdy  in  1  sink accepts; transfer when dn_val & dn_rdy.
- sat_err  out  1  sticky: a sample was clamped.
- ovf_err  out  1  sticky: a beat was dropped because the FIFO was full.

## Operation

- Shift register: loaded from cfg_shift on cfg_val. Applies to beats captured in S1 from the edge after the load. Reset value 0.
- S1: capture up_acc and up_val.
- S2: if ROUND_EN and shift > 0, add 2^(shift-1) in ACC_WIDTH+1 bits (no wrap). Then arithmetic right shift.
- S3: saturate to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - A clamped valid beat sets sat_err.
  - The clamped value is still written.
- FIFO write: at the edge after S3 when the S3 beat is valid.
  - Full with dn_rdy=0: the beat is dropped, FIFO unchanged, ovf_err set.
  - Full with a read in the same cycle: the write is accepted; count unchanged.
  - Empty with a write: dn_val rises the next cycle; no bypass of the FIFO register.
- Order is preserved; no reordering or duplication.
- up_afull is registered and high when (FIFO count + valid S1..S3 stages) ≥ AFULL. It is advisory only; beats still arrive and are accepted while space remains.
- cfg_val in the same cycle as a saturation or drop event: the set wins; the flag reads 1.
- Reset values: dn_val=0, dn_data=0, up_afull=0, sat_err=0, ovf_err=0, FIFO count=0, all stage valids 0, shift=0.

## Timing

- Latency from up_val sampled at edge N:
  - S1 at edge N, S2 at N+1, S3 at N+2.
  - FIFO write at N+3; dn_val=1 after edge N+3 (4 clocks, FIFO empty).
- Throughput: one beat per clock while the sink holds dn_rdy=1.
- dn_data is stable and dn_val stays high until the transfer.
- rst asserted mid-stream:
  - Pipeline and FIFO are flushed; in-flight beats are lost.
  - dn_val=0 after the reset edge; no output until new up_val after rst deasserts.
- Flags update on the edge after the triggering event.

## Configuration

- ROUND_EN defined: round-half-up (add half LSB before the shift).
- ROUND_EN not defined: truncate toward negative infinity (plain arithmetic shift); no adder in S2.

## Structure

- Shared header, include-guarded, holds:
  - default ACC_WIDTH/OUT_WIDTH;
  - the saturation limit expressions;
  - the clog2 helper for the FIFO pointers.
- One sub-module, stream_fifo: FWFT, parameterised WIDTH/DEPTH, outputs a count.
- filter_output instantiates stream_fifo and contains S1..S3 and the flag logic.

## Test plan

- shift=4, up_acc=296, dn_rdy=1 -> dn_data=19 with ROUND_EN, 18 without; dn_val rises 4 clocks after up_val.
- shift=4, up_acc=-296 (0xFFFFFED8) -> 0xFFEE (-18) with ROUND_EN, 0xFFED (-19) without.
- shift=0, up_acc=0x7FFFFFFF then 0x80000000 -> 0x7FFF then 0x8000; sat_err=1; cfg_val then clears it.
- dn_rdy=0, 12 consecutive beats, DEPTH=8, AFULL=4 -> up_afull high 1 clock after the 4th beat; first 8 beats stored; last 4 dropped; ovf_err=1; dn_rdy=1 drains beats 1..8 in order.
- FIFO full, dn_rdy=1 with a new beat writing the same cycle -> count stays 8; no drop; ovf_err stays 0.
- rst pulsed with 3 beats in flight and 5 in the FIFO -> dn_val=0 and up_afull=0 next cycle; next beat emerges after 4 clocks with correct value.
